// File: rtl/mem_arbiter2.sv
// Two-master arbiter for the picorv32 native memory interface; one transaction in flight.
// Optional bounded-wait termination is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter2 #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        timeout_err
);

  // Handshake: a requester holds mX_valid and its fields until mX_ready, a
  // one-cycle pulse; the downstream port holds mem_* stable until mem_ready.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        pick, load, finish, to_hit;
  logic        mem_instr_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  // On a tie, round robin hands the port to whoever did not win last time.
  always_comb begin
    if (m0_valid && m1_valid) pick = (ROUND_ROBIN != 0) ? ~grant_q : 1'b0;
    else                      pick = m1_valid;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          load    = 1'b1;
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready || to_hit) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (load) begin
        mem_instr_q <= pick ? m1_instr : m0_instr;
        mem_addr_q  <= pick ? m1_addr  : m0_addr;
        mem_wdata_q <= pick ? m1_wdata : m0_wdata;
        mem_wstrb_q <= pick ? m1_wstrb : m0_wstrb;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        timeout_err_q;

  // A real mem_ready in the terminal cycle wins over the forced termination.
  assign to_hit      = (state_q == BUSY) && !mem_ready && (to_cnt == TO_LAST);
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (load)                                to_cnt <= '0;
      else if (state_q == BUSY && !mem_ready)  to_cnt <= to_cnt + 16'd1;
      if (to_hit) timeout_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign m0_ready  = finish && !grant_q;
  assign m1_ready  = finish &&  grant_q;
  assign m0_rdata  = (to_hit && !grant_q) ? 32'hdeadbeef : mem_rdata;
  assign m1_rdata  = (to_hit &&  grant_q) ? 32'hdeadbeef : mem_rdata;
  assign mem_valid = (state_q == BUSY);
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: a round-robin and a fixed-priority instance share the
// same stimulus and are each checked every cycle against a transaction-level model.
module tb_mem_arbiter2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        d_m0_ready[2], d_m1_ready[2], d_mem_valid[2], d_mem_instr[2];
  logic        d_grant[2], d_timeout_err[2];
  logic [31:0] d_m0_rdata[2], d_m1_rdata[2], d_mem_addr[2], d_mem_wdata[2];
  logic [3:0]  d_mem_wstrb[2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter2 #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(d_m0_ready[0]), .m0_rdata(d_m0_rdata[0]),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(d_m1_ready[0]), .m1_rdata(d_m1_rdata[0]),
    .mem_valid(d_mem_valid[0]), .mem_instr(d_mem_instr[0]), .mem_addr(d_mem_addr[0]),
    .mem_wdata(d_mem_wdata[0]), .mem_wstrb(d_mem_wstrb[0]),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(d_grant[0]), .timeout_err(d_timeout_err[0])
  );

  mem_arbiter2 #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(d_m0_ready[1]), .m0_rdata(d_m0_rdata[1]),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(d_m1_ready[1]), .m1_rdata(d_m1_rdata[1]),
    .mem_valid(d_mem_valid[1]), .mem_instr(d_mem_instr[1]), .mem_addr(d_mem_addr[1]),
    .mem_wdata(d_mem_wdata[1]), .mem_wstrb(d_mem_wstrb[1]),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(d_grant[1]), .timeout_err(d_timeout_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model (index 0 = round robin, 1 = fixed)
  bit          md_busy[2], md_grant[2], md_instr[2], md_err[2];
  logic [31:0] md_addr[2], md_wdata[2];
  logic [3:0]  md_wstrb[2];
  int          md_age[2];

  function automatic bit winner(input bit v0, input bit v1, input bit last, input bit rr);
    if (v0 && v1) return rr ? !last : 1'b0;
    return v1;
  endfunction

  function automatic bit timeout_now(input int i);
`ifdef MEM_ARB_TIMEOUT_EN
    return md_busy[i] && !mem_ready && (md_age[i] == TO);
`else
    return 1'b0 & md_busy[i];
`endif
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        md_busy[i]  <= 1'b0;
        md_grant[i] <= 1'b1;
        md_err[i]   <= 1'b0;
        md_age[i]   <= 0;
      end else if (!md_busy[i]) begin
        if (m0_valid || m1_valid) begin
          md_busy[i]  <= 1'b1;
          md_age[i]   <= 1;
          md_grant[i] <= winner(m0_valid, m1_valid, md_grant[i], i == 0);
          md_instr[i] <= winner(m0_valid, m1_valid, md_grant[i], i == 0) ? m1_instr : m0_instr;
          md_addr[i]  <= winner(m0_valid, m1_valid, md_grant[i], i == 0) ? m1_addr  : m0_addr;
          md_wdata[i] <= winner(m0_valid, m1_valid, md_grant[i], i == 0) ? m1_wdata : m0_wdata;
          md_wstrb[i] <= winner(m0_valid, m1_valid, md_grant[i], i == 0) ? m1_wstrb : m0_wstrb;
        end
      end else begin
        if (mem_ready || timeout_now(i)) md_busy[i] <= 1'b0;
        if (timeout_now(i)) md_err[i] <= 1'b1;
        md_age[i] <= md_age[i] + 1;
      end
    end
  end

  // ---------------- per-cycle compare against the model
  bit    c_to, c_e0, c_e1;
  string c_p;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        c_p  = (i == 0) ? "rr " : "fp ";
        c_to = timeout_now(i);
        c_e0 = md_busy[i] && !md_grant[i] && (mem_ready || c_to);
        c_e1 = md_busy[i] &&  md_grant[i] && (mem_ready || c_to);
        chk({c_p, "mem_valid"},   32'(d_mem_valid[i]),   32'(md_busy[i]));
        chk({c_p, "grant"},       32'(d_grant[i]),       32'(md_grant[i]));
        chk({c_p, "m0_ready"},    32'(d_m0_ready[i]),    32'(c_e0));
        chk({c_p, "m1_ready"},    32'(d_m1_ready[i]),    32'(c_e1));
        chk({c_p, "timeout_err"}, 32'(d_timeout_err[i]), 32'(md_err[i]));
        if (md_busy[i]) begin
          chk({c_p, "mem_addr"},  d_mem_addr[i],         md_addr[i]);
          chk({c_p, "mem_wdata"}, d_mem_wdata[i],        md_wdata[i]);
          chk({c_p, "mem_wstrb"}, 32'(d_mem_wstrb[i]),   32'(md_wstrb[i]));
          chk({c_p, "mem_instr"}, 32'(d_mem_instr[i]),   32'(md_instr[i]));
        end
        if (c_e0) chk({c_p, "m0_rdata"}, d_m0_rdata[i], c_to ? 32'hdeadbeef : mem_rdata);
        if (c_e1) chk({c_p, "m1_rdata"}, d_m1_rdata[i], c_to ? 32'hdeadbeef : mem_rdata);
      end
    end
  end

  // ---------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [0:0] exp_q[$];
  logic [0:0] got_rr[$], got_fp[$];
  logic [0:0] g;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("reset mem_valid", 32'(d_mem_valid[0]), 32'd0);
    chk("reset grant", 32'(d_grant[0]), 32'd1);
    chk("reset mem_addr", d_mem_addr[0], 32'd0);
    chk("reset timeout_err", 32'(d_timeout_err[0]), 32'd0);

    // single read from m0, completion two cycles after mem_valid rises
    step();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'b0000; m0_instr = 1'b0;
    @(negedge clk);
    chk("read latency mem_valid", 32'(d_mem_valid[0]), 32'd0);
    step();
    @(negedge clk);
    chk("read mem_valid", 32'(d_mem_valid[0]), 32'd1);
    chk("read mem_addr", d_mem_addr[0], 32'h100);
    step();
    step();
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("read m0_ready", 32'(d_m0_ready[0]), 32'd1);
    chk("read m0_rdata", d_m0_rdata[0], 32'h12345678);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("read drop mem_valid", 32'(d_mem_valid[0]), 32'd0);

    // contention from reset; m0 gives up after four transfers
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h200; m0_wdata = 32'h0a0a0a0a; m0_wstrb = 4'b1111;
    m1_valid = 1'b1; m1_addr = 32'h300; m1_instr = 1'b1; m1_wstrb = 4'b0000;
    mem_ready = 1'b1; mem_rdata = 32'haaaa0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_m0_ready[0] || d_m1_ready[0]) got_rr.push_back(d_m1_ready[0]);
      if (d_m0_ready[1] || d_m1_ready[1]) got_fp.push_back(d_m1_ready[1]);
      step();
      mem_rdata = mem_rdata + 32'd1;
      if (c == 7) m0_valid = 1'b0;
    end
    m1_valid = 1'b0; mem_ready = 1'b0;
    chk("rr completions", 32'(got_rr.size()), 32'd6);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    while (exp_q.size() > 0) begin
      g = (got_rr.size() > 0) ? got_rr.pop_front() : 1'bx;
      chk("rr grant order", 32'(g), 32'(exp_q.pop_front()));
    end
    chk("fp completions", 32'(got_fp.size()), 32'd6);
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    while (exp_q.size() > 0) begin
      g = (got_fp.size() > 0) ? got_fp.pop_front() : 1'bx;
      chk("fp grant order", 32'(g), 32'(exp_q.pop_front()));
    end

    // stability while BUSY, m1 write queued behind m0
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h40; m0_instr = 1'b1; m0_wdata = '0; m0_wstrb = '0;
    step();
    m0_addr = 32'hffff;
    m1_valid = 1'b1; m1_addr = 32'h80; m1_wdata = 32'hcafe0001; m1_wstrb = 4'b0011; m1_instr = 1'b0;
    @(negedge clk);
    chk("stable mem_addr 1", d_mem_addr[0], 32'h40);
    chk("stable mem_instr", 32'(d_mem_instr[0]), 32'd1);
    step();
    @(negedge clk);
    chk("stable mem_addr 2", d_mem_addr[0], 32'h40);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00000055;
    @(negedge clk);
    chk("stable mem_addr 3", d_mem_addr[0], 32'h40);
    chk("stable m0_ready", 32'(d_m0_ready[0]), 32'd1);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00000066;
    @(negedge clk);
    chk("write grant", 32'(d_grant[0]), 32'd1);
    chk("write mem_wstrb", 32'(d_mem_wstrb[0]), 32'h3);
    chk("write mem_wdata", d_mem_wdata[0], 32'hcafe0001);
    chk("write m1_ready", 32'(d_m1_ready[0]), 32'd1);
    step();
    m1_valid = 1'b0; mem_ready = 1'b0;

    // reset while BUSY abandons the transfer
    m0_valid = 1'b1; m0_addr = 32'h60; m0_wdata = 32'h11112222; m0_wstrb = 4'b1111; m0_instr = 1'b0;
    step();
    @(negedge clk);
    chk("midrst busy", 32'(d_mem_valid[0]), 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst no ready", 32'(d_m0_ready[0]), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst mem_valid", 32'(d_mem_valid[0]), 32'd0);
    chk("midrst grant", 32'(d_grant[0]), 32'd1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00000077;
    @(negedge clk);
    chk("midrst regrant", 32'(d_grant[0]), 32'd0);
    chk("midrst mem_addr", d_mem_addr[0], 32'h60);
    chk("midrst m0_ready", 32'(d_m0_ready[0]), 32'd1);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;

    // m1 request with mem_ready held low
    m1_valid = 1'b1; m1_addr = 32'h500; m1_wstrb = 4'b0000; m1_instr = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      step();
      @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
      chk("timeout m1_ready", 32'(d_m1_ready[0]), (k == TO) ? 32'd1 : 32'd0);
      if (k == TO) chk("timeout m1_rdata", d_m1_rdata[0], 32'hdeadbeef);
`else
      chk("wait m1_ready", 32'(d_m1_ready[0]), 32'd0);
`endif
    end
    step();
`ifdef MEM_ARB_TIMEOUT_EN
    m1_valid = 1'b0;
    @(negedge clk);
    chk("timeout err set", 32'(d_timeout_err[0]), 32'd1);
    chk("timeout mem_valid", 32'(d_mem_valid[0]), 32'd0);
`else
    mem_ready = 1'b1; mem_rdata = 32'h00000099;
    @(negedge clk);
    chk("late m1_ready", 32'(d_m1_ready[0]), 32'd1);
    chk("no timeout_err", 32'(d_timeout_err[0]), 32'd0);
    step();
    m1_valid = 1'b0; mem_ready = 1'b0;
`endif
    m0_valid = 1'b1; m0_addr = 32'h700;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h000000aa;
    @(negedge clk);
    chk("after m0_ready", 32'(d_m0_ready[0]), 32'd1);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout err sticky", 32'(d_timeout_err[0]), 32'd1);
`else
    chk("timeout err tied", 32'(d_timeout_err[0]), 32'd0);
`endif
    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master arbiter for the picorv32 native memory interface (valid/ready, addr/wdata/wstrb/rdata, instr flag).
- Shares one downstream memory port between requester 0 (e.g. CPU core) and requester 1 (e.g. DMA or debug master).
- Sits between the masters and the memory/bus adapter.
- Round-robin or fixed priority; one transaction in flight; downstream request fields held stable for the whole transaction.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = requester 0 always wins.
- TIMEOUT_CYCLES, 255, max BUSY cycles without mem_ready before forced termination (only with MEM_ARB_TIMEOUT_EN); range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_valid, m1_valid  in  1  request from requester 0/1
- m0_instr, m1_instr  in  1  instruction-fetch flag
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read
- m0_ready, m1_ready  out  1  transfer complete, one-cycle pulse
- m0_rdata, m1_rdata  out  32  read data, valid with mX_ready
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream instr flag
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- grant  out  1  index of current/last granted requester
- timeout_err  out  1  sticky timeout flag

Behaviour:
- FSM states IDLE and BUSY.
- Reset values: state IDLE, mem_valid 0, mem_instr/addr/wdata/wstrb 0, grant 1 (so requester 0 wins the first tie), timeout_err 0.
- IDLE:
  - No mX_valid: stay in IDLE.
  - Exactly one mX_valid: select that requester.
  - Both valid, ROUND_ROBIN=1: select the requester != grant.
  - Both valid, ROUND_ROBIN=0: select requester 0.
  - On selection: latch that requester's instr/addr/wdata/wstrb into the mem_* registers, set grant, set mem_valid=1, go BUSY.
  - Arbitration latency: mem_valid rises the cycle after mX_valid is sampled.
- BUSY:
  - mem_* outputs are constant while mem_valid=1.
  - Changes on the granted requester's inputs are ignored until the next IDLE.
- Completion:
  - In BUSY with mem_ready=1: m[grant]_ready=1 combinationally in the same cycle.
  - m[grant]_rdata = mem_rdata in the same cycle.
  - Next edge: mem_valid=0, state IDLE.
  - Every transaction costs at least 1 IDLE cycle, so the minimum turnaround is 2 cycles per transfer.
- Ready and rdata outside completion:
  - Non-granted requester: mX_ready is always 0.
  - mX_rdata = mem_rdata whenever that requester is not being forced by a timeout; it is don't-care when mX_ready=0.
- Requester protocol (picorv32 native):
  - Requester holds mX_valid and its fields until mX_ready.
  - Requester drops mX_valid the cycle after mX_ready, so IDLE never re-grants a stale request.
- mem_ready in IDLE is ignored.
- A request arriving while BUSY waits. It is granted in the next IDLE cycle, subject to priority.
- Reset mid-transaction: next cycle mem_valid=0, state IDLE, no mX_ready pulse; the in-flight transfer is abandoned.
- grant flips only on a new selection; with ROUND_ROBIN=1 it records the last winner.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with mem_ready=0.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, the arbiter pulses m[grant]_ready=1 with m[grant]_rdata=32'hdeadbeef.
  - It also sets timeout_err=1 (sticky until reset) and drops mem_valid on the next edge, returning to IDLE.
  - mem_ready=1 in that same cycle takes precedence: normal completion, no error.
- Without the macro: no counter, BUSY waits indefinitely, timeout_err tied to 0.

Test Plan:
- Single read: m0_valid=1, addr 32'h100, wstrb 0 -> mem_valid=1 next cycle with mem_addr=32'h100; mem_ready=1 with mem_rdata=32'h12345678 two cycles later -> m0_ready pulse with m0_rdata=32'h12345678, mem_valid=0 the following cycle.
- Contention, round robin: both valid continuously from reset -> grants in order 0,1,0,1; each requester completes one transfer per two grants; m1_ready never high during a grant=0 transaction.
- Fixed priority (ROUND_ROBIN=0): both valid for 3 transactions -> all three grants go to 0; m1 is granted only after m0_valid drops.
- Stability: change m0_addr to 32'hffff while BUSY with 3-cycle mem_ready latency -> mem_addr stays at its original value; write with m1_wstrb=4'b0011, wdata 32'hcafe0001 -> mem_wstrb and mem_wdata match exactly.
- Reset mid-op: assert reset in BUSY before mem_ready -> mem_valid=0 and grant=1 next cycle; no mX_ready pulse; a subsequent m0 request is granted normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m1 request, mem_ready held 0 -> m1_ready pulse with m1_rdata=32'hdeadbeef in the 4th BUSY cycle; timeout_err=1 and remains 1 after later successful transfers.
